// File: rtl/cmp_track_32.sv
// cmp_track_32: per-frame statistics on the output of the 32-bit magnitude
// comparator. Counts outcome flags, tracks the running max/min of all accepted
// operands and flags malformed (non-one-hot) flag sets. Results hold after
// the frame until the next accepted start or reset.
//
// Handshake: a pair is accepted on a rising edge where in_valid and in_ready
// are both high; in_ready depends only on the state register (high in RUN),
// never on in_valid, and a pair offered while in_ready is low is dropped.
module cmp_track_32 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      P,
  input  logic [31:0]      Q,
  input  logic             PBIG,
  input  logic             SAME,
  input  logic             QBIG,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pbig_cnt,
  output logic [CNT_W-1:0] same_cnt,
  output logic [CNT_W-1:0] qbig_cnt,
  output logic [31:0]      max_val,
  output logic [31:0]      min_val,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] acc_cnt;   // pairs accepted so far in this frame
  logic             first_q;   // next accepted pair is the first of the frame

  logic             accept;
  logic             last_pair;
  logic             onehot;
  logic [31:0]      hi;
  logic [31:0]      lo;

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign accept    = in_valid & in_ready;
  // len_q is never zero while in RUN, so len_q - 1 cannot wrap.
  assign last_pair = (acc_cnt == (len_q - ONE));
  // Odd number of flags set, excluding the all-three case, is exactly one.
  assign onehot    = (PBIG ^ SAME ^ QBIG) & ~(PBIG & SAME & QBIG);
  // Flags are trusted for ordering, even on an error pair.
  assign hi        = PBIG ? P : Q;
  assign lo        = PBIG ? Q : P;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:  if (accept && last_pair) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame setup on accepted start, then per-pair statistics update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      acc_cnt  <= '0;
      first_q  <= 1'b1;
      pbig_cnt <= '0;
      same_cnt <= '0;
      qbig_cnt <= '0;
      max_val  <= '0;
      min_val  <= '0;
      err      <= 1'b0;
    end else if (state == IDLE && start) begin
      len_q    <= len;
      acc_cnt  <= '0;
      first_q  <= 1'b1;
      pbig_cnt <= '0;
      same_cnt <= '0;
      qbig_cnt <= '0;
      max_val  <= '0;
      min_val  <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + ONE;
      first_q <= 1'b0;
      if (onehot) begin
        if (PBIG && pbig_cnt != '1) pbig_cnt <= pbig_cnt + ONE;
        if (SAME && same_cnt != '1) same_cnt <= same_cnt + ONE;
        if (QBIG && qbig_cnt != '1) qbig_cnt <= qbig_cnt + ONE;
      end else begin
        err <= 1'b1;
      end
      if (first_q) begin
        max_val <= hi;
        min_val <= lo;
      end else begin
        if (hi > max_val) max_val <= hi;
        if (lo < min_val) min_val <= lo;
      end
    end
  end

endmodule

// File: tb/tb_cmp_track_32.sv
// Bench for cmp_track_32: directed frames driven into a default-width and a
// 4-bit-counter instance in parallel, checked every cycle against a
// frame-level model, plus literal expectations at key points.
module tb_cmp_track_32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] p, q;
  logic        pbig, same, qbig;

  always #5 clk = ~clk;

  // default-width instance
  logic        a_ready, a_busy, a_done, a_err;
  logic [15:0] a_pb, a_sm, a_qb;
  logic [31:0] a_max, a_min;
  logic [1:0]  a_dbg;
  // CNT_W=4 instance
  logic        b_ready, b_busy, b_done, b_err;
  logic [3:0]  b_pb, b_sm, b_qb;
  logic [31:0] b_max, b_min;
  logic [1:0]  b_dbg;

  cmp_track_32 dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(a_ready), .P(p), .Q(q), .PBIG(pbig), .SAME(same), .QBIG(qbig),
    .busy(a_busy), .done(a_done), .pbig_cnt(a_pb), .same_cnt(a_sm),
    .qbig_cnt(a_qb), .max_val(a_max), .min_val(a_min), .err(a_err),
    .dbg_state(a_dbg)
  );

  cmp_track_32 #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len[3:0]), .in_valid(in_valid),
    .in_ready(b_ready), .P(p), .Q(q), .PBIG(pbig), .SAME(same), .QBIG(qbig),
    .busy(b_busy), .done(b_done), .pbig_cnt(b_pb), .same_cnt(b_sm),
    .qbig_cnt(b_qb), .max_val(b_max), .min_val(b_min), .err(b_err),
    .dbg_state(b_dbg)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          m_left  = 0;    // pairs still to be accepted in this frame
  bit          m_done  = 1'b0;
  int          m_pb    = 0;
  int          m_sm    = 0;
  int          m_qb    = 0;
  logic [31:0] m_max   = '0;
  logic [31:0] m_min   = '0;
  bit          m_err   = 1'b0;
  bit          m_first = 1'b1;

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic model_clear();
    m_pb = 0; m_sm = 0; m_qb = 0;
    m_max = '0; m_min = '0; m_err = 1'b0; m_first = 1'b1;
  endtask

  task automatic model_pair();
    int ones;
    logic [31:0] hi, lo;
    ones = int'(pbig) + int'(same) + int'(qbig);
    hi = pbig ? p : q;
    lo = pbig ? q : p;
    if (ones == 1) begin
      if (pbig) m_pb++;
      if (same) m_sm++;
      if (qbig) m_qb++;
    end else begin
      m_err = 1'b1;
    end
    if (m_first) begin
      m_max = hi; m_min = lo; m_first = 1'b0;
    end else begin
      if (hi > m_max) m_max = hi;
      if (lo < m_min) m_min = lo;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_left = 0; m_done = 1'b0; model_clear();
    end else if (m_left > 0) begin
      if (in_valid) begin
        model_pair();
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      model_clear();
      if (len == 16'd0) m_done = 1'b1;
      else m_left = int'(len);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("a_ready", {31'b0, a_ready}, {31'b0, m_left > 0});
    chk("a_busy",  {31'b0, a_busy},  {31'b0, m_left > 0});
    chk("a_done",  {31'b0, a_done},  {31'b0, m_done});
    chk("a_pbig",  {16'b0, a_pb}, sat(m_pb, 65535));
    chk("a_same",  {16'b0, a_sm}, sat(m_sm, 65535));
    chk("a_qbig",  {16'b0, a_qb}, sat(m_qb, 65535));
    chk("a_max",   a_max, m_max);
    chk("a_min",   a_min, m_min);
    chk("a_err",   {31'b0, a_err},   {31'b0, m_err});
    chk("b_ready", {31'b0, b_ready}, {31'b0, m_left > 0});
    chk("b_done",  {31'b0, b_done},  {31'b0, m_done});
    chk("b_pbig",  {28'b0, b_pb}, sat(m_pb, 15));
    chk("b_same",  {28'b0, b_sm}, sat(m_sm, 15));
    chk("b_qbig",  {28'b0, b_qb}, sat(m_qb, 15));
    chk("b_max",   b_max, m_max);
    chk("b_min",   b_min, m_min);
    chk("b_err",   {31'b0, b_err},   {31'b0, m_err});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] pp, input logic [31:0] qq,
                      input logic [2:0] fl, input logic v);
    p = pp; q = qq; {pbig, same, qbig} = fl; in_valid = v;
    tick();
  endtask

  task automatic end_frame();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    p = '0; q = '0; pbig = 1'b0; same = 1'b0; qbig = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_max", a_max, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);

    // idle traffic must be ignored
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 3'b100, 1'b1);
    in_valid = 1'b0;
    chk("idle_pbig", {16'b0, a_pb}, 32'd0);
    chk("idle_max", a_max, 32'd0);

    // basic frame
    do_start(16'd3);
    send(32'd5, 32'd3, 3'b100, 1'b1);
    send(32'd7, 32'd7, 3'b010, 1'b1);
    send(32'd2, 32'd9, 3'b001, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_done", {31'b0, a_done}, 32'd1);
    chk("basic_ready", {31'b0, a_ready}, 32'd0);
    tick();
    chk("basic_pbig", {16'b0, a_pb}, 32'd1);
    chk("basic_same", {16'b0, a_sm}, 32'd1);
    chk("basic_qbig", {16'b0, a_qb}, 32'd1);
    chk("basic_max", a_max, 32'd9);
    chk("basic_min", a_min, 32'd2);
    chk("basic_err", {31'b0, a_err}, 32'd0);
    tick();

    // gapped input
    do_start(16'd4);
    send(32'hFFFF_FFFF, 32'd0, 3'b100, 1'b1);
    send($urandom, $urandom, 3'b001, 1'b0);
    send(32'd0, 32'd0, 3'b010, 1'b1);
    send($urandom, $urandom, 3'b111, 1'b0);
    send(32'd0, 32'd0, 3'b010, 1'b1);
    send(32'd0, 32'd0, 3'b010, 1'b1);
    end_frame();
    chk("gap_max", a_max, 32'hFFFF_FFFF);
    chk("gap_min", a_min, 32'd0);
    chk("gap_same", {16'b0, a_sm}, 32'd3);
    chk("gap_pbig", {16'b0, a_pb}, 32'd1);

    // error flags
    do_start(16'd2);
    send(32'd4, 32'd1, 3'b101, 1'b1);
    send(32'd1, 32'd1, 3'b010, 1'b1);
    end_frame();
    tick(); tick();
    chk("err_err", {31'b0, a_err}, 32'd1);
    chk("err_pbig", {16'b0, a_pb}, 32'd0);
    chk("err_qbig", {16'b0, a_qb}, 32'd0);
    chk("err_same", {16'b0, a_sm}, 32'd1);
    chk("err_max", a_max, 32'd4);
    chk("err_min", a_min, 32'd1);

    // len = 0
    do_start(16'd0);
    @(negedge clk);
    chk("len0_done", {31'b0, a_done}, 32'd1);
    chk("len0_err", {31'b0, a_err}, 32'd0);
    chk("len0_max", a_max, 32'd0);
    tick(); tick();

    // start during RUN is ignored
    do_start(16'd3);
    send(32'd10, 32'd1, 3'b100, 1'b1);
    start = 1'b1; len = 16'd5;
    send(32'd20, 32'd2, 3'b100, 1'b1);
    start = 1'b0;
    send(32'd30, 32'd3, 3'b100, 1'b1);
    end_frame();
    chk("restart_pbig", {16'b0, a_pb}, 32'd3);
    chk("restart_max", a_max, 32'd30);
    chk("restart_min", a_min, 32'd1);

    // two full 15-pair frames on the 4-bit counters
    for (int f = 0; f < 2; f++) begin
      do_start(16'd15);
      for (int i = 0; i < 15; i++) send($urandom, $urandom, 3'b100, 1'b1);
      end_frame();
      chk("sat_b_pbig", {28'b0, b_pb}, 32'd15);
      chk("sat_a_pbig", {16'b0, a_pb}, 32'd15);
    end

    // reset mid-frame
    do_start(16'd15);
    for (int i = 0; i < 7; i++) send($urandom | 32'd1, $urandom, 3'b100, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, a_busy}, 32'd0);
    chk("mrst_pbig", {16'b0, a_pb}, 32'd0);
    chk("mrst_max", a_max, 32'd0);
    chk("mrst_b_pbig", {28'b0, b_pb}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
